act_buffer_responder: RTL and testbench
=======================================

Name: act_buffer_responder

Overview:
- Activation-memory responder serving the nonlinear/pooling path.
- Answers the block's activation reads (rd_en, rd_addr, returns an N-lane read_word) and absorbs its result writes (wr_en, wr_addr, N-lane word).
- Arbitrates a host load port against the result writes, and raises a completion pulse once the expected number of result words has landed.

Parameters:
- N_DIM_ARRAY, 8, lanes per word
- INPUT_CHANNEL_DATA_WIDTH, 8, signed bits per lane
- INPUT_CHANNEL_ADDR_SIZE, 10, address width
- DEPTH, 768, implemented words (≤ 2^INPUT_CHANNEL_ADDR_SIZE)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- input_channel_rd_en  in  1  read request
- input_channel_rd_addr  in  INPUT_CHANNEL_ADDR_SIZE  read address
- read_word  out  N_DIM_ARRAY x INPUT_CHANNEL_DATA_WIDTH  read data, signed lanes
- read_valid  out  1  read_word valid this cycle
- wr_en_output_buffer_nl  in  1  result write strobe
- wr_addr_nl  in  INPUT_CHANNEL_ADDR_SIZE  result write address
- output_word  in  N_DIM_ARRAY x INPUT_CHANNEL_DATA_WIDTH  result write data
- ext_wr_valid  in  1  host load request
- ext_wr_ready  out  1  host load accepted
- ext_wr_addr  in  INPUT_CHANNEL_ADDR_SIZE  host address
- ext_wr_data  in  N_DIM_ARRAY x INPUT_CHANNEL_DATA_WIDTH  host data
- clear_count  in  1  synchronous clear of completion counter
- NUMBER_OF_ACTIVATION_CYCLES  in  16  expected result writes
- result_count  out  16  accepted result writes since clear
- all_written  out  1  one-cycle completion pulse
- addr_error  out  1  sticky out-of-range flag

Behaviour:
- Reset values: read_word all lanes 0, read_valid 0, result_count 0, all_written 0, addr_error 0. Memory array is not reset. ext_wr_ready is combinational and not affected by reset.
- Read latency:
  - Request at edge k gives read_word and read_valid at edge k+1.
  - read_word holds its last value while no read is issued.
  - read_valid is 0 on any cycle without a preceding request.
- Write priority: result write beats host write.
  - ext_wr_ready = !wr_en_output_buffer_nl.
  - Host write commits only when ext_wr_valid && ext_wr_ready.
  - A stalled host request keeps its addr/data stable until accepted.
- Read/write same address, same cycle: write-first. read_word returns the newly written word from whichever write commits.
- Out-of-range address (addr ≥ DEPTH):
  - Reads return all-zero lanes, still with read_valid = 1.
  - Writes are dropped.
  - Either case sets addr_error = 1, held until reset.
- Completion counter:
  - Increments once per accepted in-range result write.
  - all_written pulses for one cycle on the edge where the count reaches NUMBER_OF_ACTIVATION_CYCLES; the count returns to 0 on that same edge.
  - NUMBER_OF_ACTIVATION_CYCLES = 0 never pulses; the count saturates at 16'hFFFF.
  - clear_count zeroes the count and wins over a simultaneous increment; no pulse on that cycle.
- Reset mid-operation:
  - Outputs return to reset values immediately.
  - Any in-flight read result is lost.
  - Memory contents are preserved.
- Lane arithmetic: none. Data passes bit-exact, signed.

Optional Feature:
- Macro: ACT_BUFFER_OUT_REG_EN.
- Defined: an extra output register stage is added.
  - Read latency becomes 2 cycles; read_valid is delayed to match.
  - Write-first forwarding still applies to the write in the request cycle.
  - The output register resets to 0.
- Undefined: 1-cycle latency as specified above.

Test Plan:
- Basic write/read: host writes word lanes 0..7 = {1,-2,3,-4,5,-6,7,-8} to addr 5, then read 5 → next cycle read_word equals that word, read_valid = 1.
- Write-first: result write of lanes all 8'h7F to addr 9, same-cycle read of addr 9 → read_word all 8'h7F next cycle.
- Arbitration: ext_wr_valid and wr_en_output_buffer_nl both high for 3 cycles on different addrs → ext_wr_ready = 0 for those 3 cycles; host word commits on the 4th cycle; both addresses read back correctly.
- Completion: NUMBER_OF_ACTIVATION_CYCLES = 4, four result writes with gaps → all_written high exactly on the 4th accepted write; result_count returns to 0; a 5th write gives result_count = 1.
- Out of range: read of addr 800 → read_word 0, read_valid = 1, addr_error = 1. A write to addr 800 does not alter addr 800 mod DEPTH (= 32).
- Reset mid-read: assert reset the cycle after a read request → read_valid 0, read_word 0. After release, the previously written addr 5 still returns its data.

Source files
------------

// File: rtl/act_buffer_responder.sv
// Activation buffer responder: N-lane word memory with 1-cycle reads, result-write priority
// over host loads, and a completion counter. Define ACT_BUFFER_OUT_REG_EN for a 2-cycle read path.
module act_buffer_responder #(
  parameter int N_DIM_ARRAY              = 8,
  parameter int INPUT_CHANNEL_DATA_WIDTH = 8,
  parameter int INPUT_CHANNEL_ADDR_SIZE  = 10,
  parameter int DEPTH                    = 768
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              input_channel_rd_en,
  input  logic [INPUT_CHANNEL_ADDR_SIZE-1:0]                input_channel_rd_addr,
  output logic [N_DIM_ARRAY*INPUT_CHANNEL_DATA_WIDTH-1:0]   read_word,
  output logic                                              read_valid,
  input  logic                                              wr_en_output_buffer_nl,
  input  logic [INPUT_CHANNEL_ADDR_SIZE-1:0]                wr_addr_nl,
  input  logic [N_DIM_ARRAY*INPUT_CHANNEL_DATA_WIDTH-1:0]   output_word,
  input  logic                                              ext_wr_valid,
  output logic                                              ext_wr_ready,
  input  logic [INPUT_CHANNEL_ADDR_SIZE-1:0]                ext_wr_addr,
  input  logic [N_DIM_ARRAY*INPUT_CHANNEL_DATA_WIDTH-1:0]   ext_wr_data,
  input  logic                                              clear_count,
  input  logic [15:0]                                       NUMBER_OF_ACTIVATION_CYCLES,
  output logic [15:0]                                       result_count,
  output logic                                              all_written,
  output logic                                              addr_error
);

  localparam int WORD_W = N_DIM_ARRAY * INPUT_CHANNEL_DATA_WIDTH;
  // One extra bit so DEPTH == 2^ADDR_SIZE is still representable.
  localparam logic [INPUT_CHANNEL_ADDR_SIZE:0] DEPTH_LIMIT = (INPUT_CHANNEL_ADDR_SIZE+1)'(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];

  logic                               rd_in_range;
  logic                               nl_in_range;
  logic                               ext_in_range;
  logic                               ext_accept;
  logic                               nl_commit;
  logic                               ext_commit;
  logic                               write_commit;
  logic [INPUT_CHANNEL_ADDR_SIZE-1:0] commit_addr;
  logic [WORD_W-1:0]                  commit_data;
  logic [WORD_W-1:0]                  read_next;
  logic [WORD_W-1:0]                  stage_word;
  logic                               stage_valid;
  logic                               count_hit;

  assign rd_in_range  = {1'b0, input_channel_rd_addr} < DEPTH_LIMIT;
  assign nl_in_range  = {1'b0, wr_addr_nl} < DEPTH_LIMIT;
  assign ext_in_range = {1'b0, ext_wr_addr} < DEPTH_LIMIT;

  assign ext_wr_ready = !wr_en_output_buffer_nl;
  assign ext_accept   = ext_wr_valid && ext_wr_ready;
  assign nl_commit    = wr_en_output_buffer_nl && nl_in_range;
  assign ext_commit   = ext_accept && ext_in_range;

  // At most one write commits per cycle; the same port feeds write-first read forwarding.
  always_comb begin
    write_commit = 1'b0;
    commit_addr  = wr_addr_nl;
    commit_data  = output_word;
    if (nl_commit) begin
      write_commit = 1'b1;
    end else if (ext_commit) begin
      write_commit = 1'b1;
      commit_addr  = ext_wr_addr;
      commit_data  = ext_wr_data;
    end
  end

  always_comb begin
    read_next = '0;
    if (rd_in_range) begin
      if (write_commit && (commit_addr == input_channel_rd_addr)) begin
        read_next = commit_data;
      end else begin
        read_next = mem[input_channel_rd_addr];
      end
    end
  end

  // Storage is deliberately outside the reset domain so contents survive a reset.
  always_ff @(posedge clk) begin
    if (write_commit) begin
      mem[commit_addr] <= commit_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_word  <= '0;
      stage_valid <= 1'b0;
    end else begin
      stage_valid <= input_channel_rd_en;
      if (input_channel_rd_en) begin
        stage_word <= read_next;
      end
    end
  end

`ifdef ACT_BUFFER_OUT_REG_EN
  logic [WORD_W-1:0] out_word;
  logic              out_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_word  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_word  <= stage_word;
      out_valid <= stage_valid;
    end
  end

  assign read_word  = out_word;
  assign read_valid = out_valid;
`else
  assign read_word  = stage_word;
  assign read_valid = stage_valid;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_error <= 1'b0;
    end else if ((input_channel_rd_en && !rd_in_range) ||
                 (wr_en_output_buffer_nl && !nl_in_range) ||
                 (ext_accept && !ext_in_range)) begin
      addr_error <= 1'b1;
    end
  end

  // A target of zero can never be hit, so the count just saturates in that case.
  assign count_hit = (NUMBER_OF_ACTIVATION_CYCLES != 16'd0) &&
                     ((result_count + 16'd1) == NUMBER_OF_ACTIVATION_CYCLES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_count <= 16'd0;
      all_written  <= 1'b0;
    end else begin
      all_written <= 1'b0;
      if (clear_count) begin
        result_count <= 16'd0;
      end else if (nl_commit) begin
        if (count_hit) begin
          result_count <= 16'd0;
          all_written  <= 1'b1;
        end else if (result_count != 16'hFFFF) begin
          result_count <= result_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_act_buffer_responder.sv
// Directed self-checking bench for act_buffer_responder; expected values are hand-computed.
module tb_act_buffer_responder;

`ifdef ACT_BUFFER_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        reset;
  logic        input_channel_rd_en;
  logic [9:0]  input_channel_rd_addr;
  logic [63:0] read_word;
  logic        read_valid;
  logic        wr_en_output_buffer_nl;
  logic [9:0]  wr_addr_nl;
  logic [63:0] output_word;
  logic        ext_wr_valid;
  logic        ext_wr_ready;
  logic [9:0]  ext_wr_addr;
  logic [63:0] ext_wr_data;
  logic        clear_count;
  logic [15:0] NUMBER_OF_ACTIVATION_CYCLES;
  logic [15:0] result_count;
  logic        all_written;
  logic        addr_error;

  int checks = 0;
  int passes = 0;

  localparam logic [63:0] WORD_A5  = 64'hF807_FA05_FC03_FE01;
  localparam logic [63:0] WORD_7F  = 64'h7F7F_7F7F_7F7F_7F7F;
  localparam logic [63:0] WORD_HST = 64'h1122_3344_5566_7788;
  localparam logic [63:0] WORD_R31 = 64'h8081_8283_8485_8687;
  localparam logic [63:0] WORD_32  = 64'hA5A5_5A5A_C3C3_3C3C;

  act_buffer_responder dut (
    .clk                         (clk),
    .reset                       (reset),
    .input_channel_rd_en         (input_channel_rd_en),
    .input_channel_rd_addr       (input_channel_rd_addr),
    .read_word                   (read_word),
    .read_valid                  (read_valid),
    .wr_en_output_buffer_nl      (wr_en_output_buffer_nl),
    .wr_addr_nl                  (wr_addr_nl),
    .output_word                 (output_word),
    .ext_wr_valid                (ext_wr_valid),
    .ext_wr_ready                (ext_wr_ready),
    .ext_wr_addr                 (ext_wr_addr),
    .ext_wr_data                 (ext_wr_data),
    .clear_count                 (clear_count),
    .NUMBER_OF_ACTIVATION_CYCLES (NUMBER_OF_ACTIVATION_CYCLES),
    .result_count                (result_count),
    .all_written                 (all_written),
    .addr_error                  (addr_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    input_channel_rd_en    = 1'b0;
    wr_en_output_buffer_nl = 1'b0;
    ext_wr_valid           = 1'b0;
    clear_count            = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    input_channel_rd_addr = '0;
    wr_addr_nl = '0;
    output_word = '0;
    ext_wr_addr = '0;
    ext_wr_data = '0;
    NUMBER_OF_ACTIVATION_CYCLES = 16'd0;
    tick();
    tick();
    checks++; if (read_word !== 64'd0) $display("[TB] FAIL reset_read_word got %h exp 0", read_word); else passes++;
    checks++; if (read_valid !== 1'b0) $display("[TB] FAIL reset_read_valid got %b exp 0", read_valid); else passes++;
    checks++; if (result_count !== 16'd0) $display("[TB] FAIL reset_result_count got %0d exp 0", result_count); else passes++;
    checks++; if (all_written !== 1'b0) $display("[TB] FAIL reset_all_written got %b exp 0", all_written); else passes++;
    checks++; if (addr_error !== 1'b0) $display("[TB] FAIL reset_addr_error got %b exp 0", addr_error); else passes++;
    checks++; if (ext_wr_ready !== 1'b1) $display("[TB] FAIL reset_ext_wr_ready got %b exp 1", ext_wr_ready); else passes++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_rw();
    ext_wr_valid = 1'b1; ext_wr_addr = 10'd5; ext_wr_data = WORD_A5;
    #1;
    checks++; if (ext_wr_ready !== 1'b1) $display("[TB] FAIL basic_ready got %b exp 1", ext_wr_ready); else passes++;
    tick();
    ext_wr_valid = 1'b0;
    input_channel_rd_en = 1'b1; input_channel_rd_addr = 10'd5;
    tick();
    input_channel_rd_en = 1'b0;
    repeat (LAT-1) tick();
    checks++; if (read_word !== WORD_A5) $display("[TB] FAIL basic_read_word got %h exp %h", read_word, WORD_A5); else passes++;
    checks++; if (read_valid !== 1'b1) $display("[TB] FAIL basic_read_valid got %b exp 1", read_valid); else passes++;
    tick();
    checks++; if (read_valid !== 1'b0) $display("[TB] FAIL basic_valid_drop got %b exp 0", read_valid); else passes++;
    checks++; if (read_word !== WORD_A5) $display("[TB] FAIL basic_word_hold got %h exp %h", read_word, WORD_A5); else passes++;
  endtask

  task automatic test_write_first();
    wr_en_output_buffer_nl = 1'b1; wr_addr_nl = 10'd9; output_word = WORD_7F;
    input_channel_rd_en = 1'b1; input_channel_rd_addr = 10'd9;
    tick();
    idle_inputs();
    repeat (LAT-1) tick();
    checks++; if (read_word !== WORD_7F) $display("[TB] FAIL wf_read_word got %h exp %h", read_word, WORD_7F); else passes++;
    checks++; if (read_valid !== 1'b1) $display("[TB] FAIL wf_read_valid got %b exp 1", read_valid); else passes++;
    checks++; if (result_count !== 16'd1) $display("[TB] FAIL wf_result_count got %0d exp 1", result_count); else passes++;
  endtask

  task automatic test_arbitration();
    ext_wr_valid = 1'b1; ext_wr_addr = 10'd20; ext_wr_data = WORD_HST;
    for (int i = 0; i < 3; i++) begin
      wr_en_output_buffer_nl = 1'b1;
      wr_addr_nl = 10'd30 + 10'(i);
      output_word = (i == 1) ? WORD_R31 : 64'(i + 100);
      #1;
      checks++; if (ext_wr_ready !== 1'b0) $display("[TB] FAIL arb_stall%0d got %b exp 0", i, ext_wr_ready); else passes++;
      tick();
    end
    wr_en_output_buffer_nl = 1'b0;
    #1;
    checks++; if (ext_wr_ready !== 1'b1) $display("[TB] FAIL arb_accept got %b exp 1", ext_wr_ready); else passes++;
    tick();
    ext_wr_valid = 1'b0;
    input_channel_rd_en = 1'b1; input_channel_rd_addr = 10'd20;
    tick();
    input_channel_rd_addr = 10'd31;
    repeat (LAT-1) tick();
    checks++; if (read_word !== WORD_HST) $display("[TB] FAIL arb_host_word got %h exp %h", read_word, WORD_HST); else passes++;
    if (LAT == 1) tick();
    input_channel_rd_en = 1'b0;
    repeat (LAT-1) tick();
    checks++; if (read_word !== WORD_R31) $display("[TB] FAIL arb_result_word got %h exp %h", read_word, WORD_R31); else passes++;
    checks++; if (result_count !== 16'd4) $display("[TB] FAIL arb_result_count got %0d exp 4", result_count); else passes++;
    tick();
  endtask

  task automatic test_completion();
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    checks++; if (result_count !== 16'd0) $display("[TB] FAIL cmp_clear got %0d exp 0", result_count); else passes++;
    NUMBER_OF_ACTIVATION_CYCLES = 16'd4;
    for (int k = 1; k <= 4; k++) begin
      wr_en_output_buffer_nl = 1'b1; wr_addr_nl = 10'd40 + 10'(k); output_word = 64'(k);
      tick();
      wr_en_output_buffer_nl = 1'b0;
      checks++; if (all_written !== (k == 4)) $display("[TB] FAIL cmp_pulse%0d got %b exp %b", k, all_written, (k == 4)); else passes++;
      checks++; if (result_count !== ((k == 4) ? 16'd0 : 16'(k))) $display("[TB] FAIL cmp_count%0d got %0d exp %0d", k, result_count, (k == 4) ? 0 : k); else passes++;
      tick();
    end
    checks++; if (all_written !== 1'b0) $display("[TB] FAIL cmp_pulse_width got %b exp 0", all_written); else passes++;
    wr_en_output_buffer_nl = 1'b1; wr_addr_nl = 10'd50;
    tick();
    wr_en_output_buffer_nl = 1'b0;
    checks++; if (result_count !== 16'd1) $display("[TB] FAIL cmp_fifth got %0d exp 1", result_count); else passes++;
    wr_en_output_buffer_nl = 1'b1; clear_count = 1'b1;
    tick();
    idle_inputs();
    checks++; if (result_count !== 16'd0) $display("[TB] FAIL cmp_clear_wins got %0d exp 0", result_count); else passes++;
  endtask

  task automatic test_out_of_range();
    ext_wr_valid = 1'b1; ext_wr_addr = 10'd32; ext_wr_data = WORD_32;
    tick();
    ext_wr_valid = 1'b0;
    checks++; if (addr_error !== 1'b0) $display("[TB] FAIL oor_no_error got %b exp 0", addr_error); else passes++;
    input_channel_rd_en = 1'b1; input_channel_rd_addr = 10'd800;
    tick();
    input_channel_rd_en = 1'b0;
    repeat (LAT-1) tick();
    checks++; if (read_word !== 64'd0) $display("[TB] FAIL oor_read_word got %h exp 0", read_word); else passes++;
    checks++; if (read_valid !== 1'b1) $display("[TB] FAIL oor_read_valid got %b exp 1", read_valid); else passes++;
    checks++; if (addr_error !== 1'b1) $display("[TB] FAIL oor_addr_error got %b exp 1", addr_error); else passes++;
    wr_en_output_buffer_nl = 1'b1; wr_addr_nl = 10'd800; output_word = 64'hDEAD_BEEF_0BAD_F00D;
    tick();
    wr_en_output_buffer_nl = 1'b0;
    checks++; if (result_count !== 16'd0) $display("[TB] FAIL oor_no_count got %0d exp 0", result_count); else passes++;
    input_channel_rd_en = 1'b1; input_channel_rd_addr = 10'd32;
    tick();
    input_channel_rd_en = 1'b0;
    repeat (LAT-1) tick();
    checks++; if (read_word !== WORD_32) $display("[TB] FAIL oor_alias_intact got %h exp %h", read_word, WORD_32); else passes++;
    checks++; if (addr_error !== 1'b1) $display("[TB] FAIL oor_sticky got %b exp 1", addr_error); else passes++;
  endtask

  task automatic test_reset_mid_read();
    input_channel_rd_en = 1'b1; input_channel_rd_addr = 10'd5;
    tick();
    input_channel_rd_en = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (read_valid !== 1'b0) $display("[TB] FAIL rst_mid_valid got %b exp 0", read_valid); else passes++;
    checks++; if (read_word !== 64'd0) $display("[TB] FAIL rst_mid_word got %h exp 0", read_word); else passes++;
    checks++; if (addr_error !== 1'b0) $display("[TB] FAIL rst_mid_addr_error got %b exp 0", addr_error); else passes++;
    tick();
    reset = 1'b0;
    tick();
    checks++; if (read_valid !== 1'b0) $display("[TB] FAIL rst_lost_read got %b exp 0", read_valid); else passes++;
    input_channel_rd_en = 1'b1; input_channel_rd_addr = 10'd5;
    tick();
    input_channel_rd_en = 1'b0;
    repeat (LAT-1) tick();
    checks++; if (read_word !== WORD_A5) $display("[TB] FAIL rst_mem_kept got %h exp %h", read_word, WORD_A5); else passes++;
    checks++; if (read_valid !== 1'b1) $display("[TB] FAIL rst_read_valid got %b exp 1", read_valid); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_write_first();
    test_arbitration();
    test_completion();
    test_out_of_range();
    test_reset_mid_read();
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
